// File: rtl/rtl_settings_pkg.sv
// Shared settings for the measurement engine: CSR word indices, result array
// type, ADDR_TYPE string values and small arithmetic helpers.
package rtl_settings_pkg;

  localparam int CSR_WR_TICKS = 0;
  localparam int CSR_WR_UNITS = 1;
  localparam int CSR_RD_TICKS = 2;
  localparam int CSR_RD_WORDS = 3;
  localparam int CSR_MIN_DEL  = 4;
  localparam int CSR_MAX_DEL  = 5;
  localparam int CSR_SUM_DEL  = 6;
  localparam int CSR_RD_REQ   = 7;
  localparam int CSR_NUM      = 8;

  typedef logic [CSR_NUM-1:0][31:0] meas_result_t;

  localparam string ADDR_TYPE_BYTE = "BYTE";
  localparam string ADDR_TYPE_WORD = "WORD";

  // Widest byteenable slice bytes_count can take; callers zero-extend.
  localparam int BE_MAX_W = 256;

  function automatic int unsigned bytes_count(input logic [BE_MAX_W-1:0] be);
    int unsigned n;
    n = 0;
    for (int i = 0; i < BE_MAX_W; i++) n = n + {31'd0, be[i]};
    return n;
  endfunction

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/byteen_sum_pipe.sv
// Registered popcount adder tree for write byteenables. Leaves count PIPE_W
// byte lanes each; pair-wise sums are registered once per tree level, and a
// valid shift register tracks beats through the tree.
module byteen_sum_pipe
  import rtl_settings_pkg::*;
#(
  parameter int DATA_B_W = 64,
  parameter int PIPE_W   = 16,
  parameter int SUM_W    = $clog2(DATA_B_W) + 1
)(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_B_W-1:0] byteenable_i,
  input  logic                valid_i,
  output logic [SUM_W-1:0]    sum_o,
  output logic                valid_o,
  output logic                busy_o
);

  localparam int LEAF_W = (PIPE_W < DATA_B_W) ? PIPE_W : DATA_B_W;
  localparam int LEAVES = DATA_B_W / LEAF_W;
  localparam int STAGES = (LEAVES > 1) ? $clog2(LEAVES) : 1;
  localparam int NPAD   = 1 << STAGES;

  logic [NPAD-1:0][SUM_W-1:0]            leaf;
  logic [STAGES:1][NPAD/2-1:0][SUM_W-1:0] tree_q;
  logic [STAGES:1]                        vld_q;
  logic [STAGES:0]                        vld_pipe;

  // Leaf popcounts; padding leaves stay zero so a single leaf still gets a stage.
  always_comb begin
    leaf = '0;
    for (int j = 0; j < LEAVES; j++)
      leaf[j] = SUM_W'(bytes_count(BE_MAX_W'(byteenable_i[j*LEAF_W +: LEAF_W])));
  end

  // One registered pair-wise add per tree level; upper nodes of narrow levels hold zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tree_q <= '0;
    end else begin
      for (int j = 0; j < NPAD/2; j++)
        tree_q[1][j] <= leaf[2*j] + leaf[2*j+1];
      for (int s = 2; s <= STAGES; s++)
        for (int j = 0; j < NPAD/2; j++)
          tree_q[s][j] <= (j < (NPAD >> s)) ? tree_q[s-1][2*j] + tree_q[s-1][2*j+1] : '0;
    end
  end

  // Valid bits shifted alongside the tree levels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_pipe[STAGES-1:0];
  end

  assign vld_pipe = {vld_q, valid_i};
  assign sum_o    = tree_q[STAGES][0];
  assign valid_o  = vld_pipe[STAGES];
  assign busy_o   = |vld_pipe[STAGES:1];

endmodule

// File: rtl/amm_meas_engine.sv
// Passive Avalon-MM measurement engine: write/read throughput, read request
// count and per-burst read latency min/max/sum, all saturating 32-bit words.
// Optional macro MEAS_DELAY_HIST_EN adds hist_o, an 8-bin log2 latency histogram.
module amm_meas_engine
  import rtl_settings_pkg::*;
#(
  parameter int    AMM_BURST_W = 11,
  parameter int    DATA_B_W    = 64,
  parameter string ADDR_TYPE   = "BYTE",
  parameter int    MAX_OUTST   = 8,
  parameter int    DELAY_W     = 16,
  parameter int    PIPE_W      = 16
)(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   readdatavalid_i,
  input  logic                   waitrequest_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [AMM_BURST_W-1:0] burstcount_i,
  input  logic [DATA_B_W-1:0]    byteenable_i,
  input  logic                   test_start_i,
  output logic                   meas_busy_o,
  output logic                   trk_ovf_o,
`ifdef MEAS_DELAY_HIST_EN
  output logic [7:0][31:0]       hist_o,
`endif
  output meas_result_t           meas_result_o
);

  localparam int          IDX_W    = $clog2(MAX_OUTST);
  localparam int          PTR_W    = IDX_W + 1;
  localparam int          SUM_W    = $clog2(DATA_B_W) + 1;
  localparam logic [31:0] DEL_ONES = 32'({DELAY_W{1'b1}});

  // ---------------- read tracker ring ----------------
  logic [PTR_W-1:0]                        wr_ptr, rd_ptr;
  logic [MAX_OUTST-1:0][AMM_BURST_W-1:0]   trk_cnt;
  logic [MAX_OUTST-1:0][DELAY_W-1:0]       trk_del;
  logic [MAX_OUTST-1:0]                    trk_wait;
  logic [IDX_W-1:0]                        head, tail;
  logic                                    trk_empty, trk_full;
  logic                                    rd_acc, trk_push, beat, retire;
  logic [DELAY_W-1:0]                      head_del, head_lat;

  assign head      = rd_ptr[IDX_W-1:0];
  assign tail      = wr_ptr[IDX_W-1:0];
  assign trk_empty = (wr_ptr == rd_ptr);
  assign trk_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (tail == head);
  assign rd_acc    = read_i && !waitrequest_i;
  assign trk_push  = rd_acc && !trk_full;
  assign beat      = readdatavalid_i && !trk_empty;
  assign retire    = beat && (trk_cnt[head] <= AMM_BURST_W'(1));

  // Delay counter holds cycles before the first beat; latency is one more, saturating.
  assign head_del = trk_del[head];
  assign head_lat = (&head_del) ? head_del : head_del + 1'b1;

  // Ring pointers and per-entry beat count / delay / waiting state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      trk_cnt  <= '0;
      trk_del  <= '0;
      trk_wait <= '0;
    end else begin
      if (trk_push) wr_ptr <= wr_ptr + 1'b1;
      if (retire)   rd_ptr <= rd_ptr + 1'b1;
      for (int i = 0; i < MAX_OUTST; i++) begin
        if (trk_push && tail == IDX_W'(i)) begin
          trk_cnt[i]  <= burstcount_i;
          trk_del[i]  <= '0;
          trk_wait[i] <= 1'b1;
        end else if (beat && head == IDX_W'(i)) begin
          trk_cnt[i]  <= trk_cnt[i] - 1'b1;
          trk_wait[i] <= 1'b0;
        end else if (trk_wait[i] && !(&trk_del[i])) begin
          trk_del[i]  <= trk_del[i] + 1'b1;
        end
      end
    end
  end

  // Latency of the retiring entry, held one cycle before statistics update.
  logic [DELAY_W-1:0] lat_q;
  logic               lat_vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_q     <= '0;
      lat_vld_q <= 1'b0;
    end else begin
      lat_q     <= head_lat;
      lat_vld_q <= retire;
    end
  end

  // ---------------- write unit counting ----------------
  logic             wr_acc, wr_vld, wr_busy;
  logic [SUM_W-1:0] wr_sum;

  assign wr_acc = write_i && !waitrequest_i;

  if (ADDR_TYPE == ADDR_TYPE_WORD) begin : g_word
    logic wr_vld_q;
    // One unit per accepted beat, delayed a cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) wr_vld_q <= 1'b0;
      else       wr_vld_q <= wr_acc;
    end
    assign wr_vld  = wr_vld_q;
    assign wr_sum  = SUM_W'(1);
    assign wr_busy = wr_vld_q;
  end else begin : g_byte
    byteen_sum_pipe #(
      .DATA_B_W (DATA_B_W),
      .PIPE_W   (PIPE_W),
      .SUM_W    (SUM_W)
    ) u_sum (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byteenable_i (byteenable_i),
      .valid_i      (wr_acc),
      .sum_o        (wr_sum),
      .valid_o      (wr_vld),
      .busy_o       (wr_busy)
    );
  end

  // ---------------- result registers ----------------
  meas_result_t res_q;
  logic         ovf_q;
  logic [31:0]  lat32;

  assign lat32 = 32'(lat_q);

  // Saturating counters and latency stats; test_start overrides any increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q              <= '0;
      res_q[CSR_MIN_DEL] <= DEL_ONES;
      ovf_q              <= 1'b0;
    end else if (test_start_i) begin
      res_q              <= '0;
      res_q[CSR_MIN_DEL] <= DEL_ONES;
      ovf_q              <= 1'b0;
    end else begin
      if (rd_acc && trk_full) ovf_q <= 1'b1;
      if (write_i)
        res_q[CSR_WR_TICKS] <= sat_add32(res_q[CSR_WR_TICKS], 32'd1);
      if (wr_vld)
        res_q[CSR_WR_UNITS] <= sat_add32(res_q[CSR_WR_UNITS], 32'(wr_sum));
      if (!trk_empty)
        res_q[CSR_RD_TICKS] <= sat_add32(res_q[CSR_RD_TICKS], 32'd1);
      if (readdatavalid_i)
        res_q[CSR_RD_WORDS] <= sat_add32(res_q[CSR_RD_WORDS], 32'd1);
      if (rd_acc)
        res_q[CSR_RD_REQ]   <= sat_add32(res_q[CSR_RD_REQ], 32'd1);
      if (lat_vld_q) begin
        if (lat32 < res_q[CSR_MIN_DEL]) res_q[CSR_MIN_DEL] <= lat32;
        if (lat32 > res_q[CSR_MAX_DEL]) res_q[CSR_MAX_DEL] <= lat32;
        res_q[CSR_SUM_DEL] <= sat_add32(res_q[CSR_SUM_DEL], lat32);
      end
    end
  end

`ifdef MEAS_DELAY_HIST_EN
  logic [7:0][31:0] hist_q;
  logic [2:0]       bin;

  // Bin = floor(log2(latency)), capped at 7.
  always_comb begin
    bin = '0;
    for (int b = 1; b < 8; b++)
      if (lat32 >= (32'd1 << b)) bin = 3'(b);
  end

  // Histogram shares the statistics lag and the test_start clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             hist_q      <= '0;
    else if (test_start_i) hist_q      <= '0;
    else if (lat_vld_q)    hist_q[bin] <= sat_add32(hist_q[bin], 32'd1);
  end

  assign hist_o = hist_q;
`endif

  assign meas_result_o = res_q;
  assign trk_ovf_o     = ovf_q;
  assign meas_busy_o   = !trk_empty || wr_busy;

endmodule

// File: tb/tb_amm_meas_engine.sv
// Directed bench for amm_meas_engine with default parameters (BYTE mode,
// 64-byte bus, 8 trackers, 16-bit delay). Write path is table-driven; read
// corner cases are hand-written cycle sequences.
module tb_amm_meas_engine;
  import rtl_settings_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdv, wt, rd, wr, tstart;
  logic [10:0]  bc;
  logic [63:0]  be;
  logic         busy, ovf;
  meas_result_t res;
`ifdef MEAS_DELAY_HIST_EN
  logic [7:0][31:0] hist;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  amm_meas_engine dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .readdatavalid_i (rdv),
    .waitrequest_i   (wt),
    .read_i          (rd),
    .write_i         (wr),
    .burstcount_i    (bc),
    .byteenable_i    (be),
    .test_start_i    (tstart),
    .meas_busy_o     (busy),
    .trk_ovf_o       (ovf),
`ifdef MEAS_DELAY_HIST_EN
    .hist_o          (hist),
`endif
    .meas_result_o   (res)
  );

  typedef struct {
    logic        wr;
    logic        wt;
    logic [63:0] be;
    logic [31:0] ticks;
    logic [31:0] units;
    logic        busy;
  } wvec_t;

  wvec_t wv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    tstart = 1'b1;
    step();
    tstart = 1'b0;
  endtask

  logic [31:0] rst_exp[8];

  initial begin
    // Write table: cumulative WR_TICKS now, WR_UNITS lagging two cycles.
    wv[0] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'd0,  1'b1};
    wv[1] = '{1'b1, 1'b0, 64'h0000_0000_0000_000F, 32'd2, 32'd0,  1'b1};
    wv[2] = '{1'b1, 1'b0, 64'h0,                   32'd3, 32'd64, 1'b1};
    wv[3] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd4, 32'd68, 1'b1};
    wv[4] = '{1'b0, 1'b0, 64'h0,                   32'd4, 32'd68, 1'b0};
    wv[5] = '{1'b0, 1'b0, 64'h0,                   32'd4, 32'd68, 1'b0};
    wv[6] = '{1'b1, 1'b0, 64'h8000_0000_0000_0001, 32'd5, 32'd68, 1'b1};
    wv[7] = '{1'b0, 1'b0, 64'h0,                   32'd5, 32'd68, 1'b1};
    wv[8] = '{1'b0, 1'b0, 64'h0,                   32'd5, 32'd70, 1'b0};
    rst_exp = '{0, 0, 0, 0, 32'h0000_FFFF, 0, 0, 0};

    rst = 1'b1; rdv = 0; wt = 0; rd = 0; wr = 0; tstart = 0; bc = '0; be = '0;
    steps(3);
    rst = 1'b0;
    steps(10);

    // Reset / idle state
    for (int i = 0; i < 8; i++) chk($sformatf("reset_res[%0d]", i), res[i], rst_exp[i]);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovf",  32'(ovf),  32'd0);

    // Write path, table-driven
    for (int i = 0; i < 9; i++) begin
      wr = wv[i].wr; wt = wv[i].wt; be = wv[i].be;
      step();
      chk($sformatf("wr_ticks[%0d]", i), res[CSR_WR_TICKS], wv[i].ticks);
      chk($sformatf("wr_units[%0d]", i), res[CSR_WR_UNITS], wv[i].units);
      chk($sformatf("wr_busy[%0d]", i),  32'(busy),         32'(wv[i].busy));
    end
    wr = 0; wt = 0; be = '0;

    // Single read, burst 4, first beat 5 cycles after accept
    pulse_start();
    chk("start_wr_units", res[CSR_WR_UNITS], 32'd0);
    rd = 1; bc = 11'd4; step(); rd = 0;
    chk("r1_busy_inflight", 32'(busy), 32'd1);
    steps(4);
    rdv = 1; steps(4); rdv = 0;
    chk("r1_busy_after", 32'(busy), 32'd0);
    step();
    chk("r1_rd_req",   res[CSR_RD_REQ],   32'd1);
    chk("r1_rd_words", res[CSR_RD_WORDS], 32'd4);
    chk("r1_min",      res[CSR_MIN_DEL],  32'd5);
    chk("r1_max",      res[CSR_MAX_DEL],  32'd5);
    chk("r1_sum",      res[CSR_SUM_DEL],  32'd5);
    chk("r1_rd_ticks", res[CSR_RD_TICKS], 32'd8);

    // Eight back-to-back reads, latencies 3..10
    pulse_start();
    bc = 11'd1;
    for (int c = 0; c < 20; c++) begin
      rd  = (c < 8);
      rdv = (c >= 3 && c <= 17 && (c % 2) == 1);
      step();
    end
    rd = 0; rdv = 0;
    chk("r8_min",      res[CSR_MIN_DEL],  32'd3);
    chk("r8_max",      res[CSR_MAX_DEL],  32'd10);
    chk("r8_sum",      res[CSR_SUM_DEL],  32'd52);
    chk("r8_ovf",      32'(ovf),          32'd0);
    chk("r8_rd_req",   res[CSR_RD_REQ],   32'd8);
    chk("r8_rd_words", res[CSR_RD_WORDS], 32'd8);
    chk("r8_busy",     32'(busy),         32'd0);

    // Tracker full: 9th accept overflows
    pulse_start();
    rd = 1; steps(8);
    chk("full_ovf_at8", 32'(ovf), 32'd0);
    step(); rd = 0;
    chk("full_ovf_at9",  32'(ovf),        32'd1);
    chk("full_rd_req",   res[CSR_RD_REQ], 32'd9);
    chk("full_busy",     32'(busy),       32'd1);
    rdv = 1; steps(9); rdv = 0;
    steps(2);
    chk("full_drain_busy", 32'(busy),         32'd0);
    chk("full_rd_words",   res[CSR_RD_WORDS], 32'd9);
    chk("full_min",        res[CSR_MIN_DEL],  32'd9);
    chk("full_max",        res[CSR_MAX_DEL],  32'd9);
    chk("full_sum",        res[CSR_SUM_DEL],  32'd72);
    chk("full_ovf_sticky", 32'(ovf),          32'd1);

    // test_start with two reads in flight
    pulse_start();
    chk("ts_ovf_clear", 32'(ovf), 32'd0);
    bc = 11'd2; rd = 1; step();
    bc = 11'd1; step();
    rd = 0; step();
    pulse_start();
    chk("ts_rd_req",   res[CSR_RD_REQ],   32'd0);
    chk("ts_rd_ticks", res[CSR_RD_TICKS], 32'd0);
    chk("ts_min",      res[CSR_MIN_DEL],  32'h0000_FFFF);
    chk("ts_busy",     32'(busy),         32'd1);
    step();
    rdv = 1; steps(2); rdv = 0;
    step();
    rdv = 1; step(); rdv = 0;
    steps(2);
    chk("ts_rd_words", res[CSR_RD_WORDS], 32'd3);
    chk("ts_min2",     res[CSR_MIN_DEL],  32'd5);
    chk("ts_max2",     res[CSR_MAX_DEL],  32'd7);
    chk("ts_sum2",     res[CSR_SUM_DEL],  32'd12);
    chk("ts_rd_ticks2", res[CSR_RD_TICKS], 32'd5);
    chk("ts_rd_req2",  res[CSR_RD_REQ],   32'd0);

    // Delay counter saturation on a very long stall
    pulse_start();
    bc = 11'd1; rd = 1; step(); rd = 0;
    steps(70000);
    rdv = 1; step(); rdv = 0;
    steps(2);
    chk("sat_max",      res[CSR_MAX_DEL],  32'h0000_FFFF);
    chk("sat_min",      res[CSR_MIN_DEL],  32'h0000_FFFF);
    chk("sat_sum",      res[CSR_SUM_DEL],  32'h0000_FFFF);
    chk("sat_rd_ticks", res[CSR_RD_TICKS], 32'd70001);
    chk("sat_busy",     32'(busy),         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
